dram_arbiter: RTL and testbench

Two-port arbiter sharing the single DRAM request port (`addr_dram`/`din_dram`/`rw_dram`/`valid_dram` out, `ready_dram`/`dout_dram` in) between the core's instruction-fetch requester (port 0) and load/store requester (port 1). It sits inside `core`, between the two memory requesters and the DRAM interface. It is clocked by the core clock `clk`. It allows one outstanding DRAM transaction at a time, arbitrates round-robin, and returns read data on the granted port with a one-cycle completion pulse.

---
 rtl/dram_arbiter_if.sv | 45 ++++
 rtl/dram_arbiter.sv | 129 ++++++++++++
 tb/tb_dram_arbiter.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_arbiter_if.sv
// Request/response bundle between dram_arbiter, its two requesters and the DRAM port.
// The arbiter connects through the slave modport; the requesters and DRAM model use master.
interface dram_arbiter_if #(
    parameter int unsigned ADDR_W = 27,
    parameter int unsigned DATA_W = 32
);
    logic              p0_valid;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_din;
    logic              p0_rw;
    logic              p0_ready;
    logic [DATA_W-1:0] p0_dout;

    logic              p1_valid;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_din;
    logic              p1_rw;
    logic              p1_ready;
    logic [DATA_W-1:0] p1_dout;

    logic [ADDR_W-1:0] addr_dram;
    logic [DATA_W-1:0] din_dram;
    logic              rw_dram;
    logic              valid_dram;
    logic              ready_dram;
    logic [DATA_W-1:0] dout_dram;

    modport slave (
        input  p0_valid, p0_addr, p0_din, p0_rw,
        output p0_ready, p0_dout,
        input  p1_valid, p1_addr, p1_din, p1_rw,
        output p1_ready, p1_dout,
        output addr_dram, din_dram, rw_dram, valid_dram,
        input  ready_dram, dout_dram
    );

    modport master (
        output p0_valid, p0_addr, p0_din, p0_rw,
        input  p0_ready, p0_dout,
        output p1_valid, p1_addr, p1_din, p1_rw,
        input  p1_ready, p1_dout,
        input  addr_dram, din_dram, rw_dram, valid_dram,
        output ready_dram, dout_dram
    );
endinterface

// File: rtl/dram_arbiter.sv
// Shares one DRAM request port between instruction fetch (port 0) and load/store (port 1),
// one transaction in flight. Define DRAM_ARB_FIXED_PRIO_EN to make port 1 win every tie.
module dram_arbiter #(
    parameter int unsigned ADDR_W = 27,
    parameter int unsigned DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    dram_arbiter_if.slave  bus,
    output logic           busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              grant_q, grant_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] p0_dout_q, p0_dout_d;
    logic [DATA_W-1:0] p1_dout_q, p1_dout_d;
    logic              p0_ready_q, p0_ready_d;
    logic              p1_ready_q, p1_ready_d;
    logic              busy_q, busy_d;
    logic              win1;

`ifdef DRAM_ARB_FIXED_PRIO_EN
    assign win1 = bus.p1_valid;
`else
    logic last_grant_q, last_grant_d;
    // On a tie the port that did not win last time goes next.
    assign win1 = bus.p1_valid & (~bus.p0_valid | ~last_grant_q);
`endif

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        valid_d    = valid_q;
        addr_d     = addr_q;
        din_d      = din_q;
        rw_d       = rw_q;
        p0_dout_d  = p0_dout_q;
        p1_dout_d  = p1_dout_q;
        p0_ready_d = 1'b0;
        p1_ready_d = 1'b0;
`ifndef DRAM_ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.p0_valid || bus.p1_valid) begin
                    grant_d = win1;
                    addr_d  = win1 ? bus.p1_addr : bus.p0_addr;
                    din_d   = win1 ? bus.p1_din  : bus.p0_din;
                    rw_d    = win1 ? bus.p1_rw   : bus.p0_rw;
                    valid_d = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.ready_dram) begin
                    valid_d = 1'b0;
                    if (!rw_q) begin
                        if (grant_q) p1_dout_d = bus.dout_dram;
                        else         p0_dout_d = bus.dout_dram;
                    end
`ifndef DRAM_ARB_FIXED_PRIO_EN
                    last_grant_d = grant_q;
`endif
                    // Completion pulse is registered so it lines up exactly with DONE.
                    p0_ready_d = ~grant_q;
                    p1_ready_d = grant_q;
                    state_d    = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            valid_q    <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            rw_q       <= 1'b0;
            p0_dout_q  <= '0;
            p1_dout_q  <= '0;
            p0_ready_q <= 1'b0;
            p1_ready_q <= 1'b0;
            busy_q     <= 1'b0;
`ifndef DRAM_ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            rw_q       <= rw_d;
            p0_dout_q  <= p0_dout_d;
            p1_dout_q  <= p1_dout_d;
            p0_ready_q <= p0_ready_d;
            p1_ready_q <= p1_ready_d;
            busy_q     <= busy_d;
`ifndef DRAM_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign bus.addr_dram  = addr_q;
    assign bus.din_dram   = din_q;
    assign bus.rw_dram    = rw_q;
    assign bus.valid_dram = valid_q;
    assign bus.p0_dout    = p0_dout_q;
    assign bus.p1_dout    = p1_dout_q;
    assign bus.p0_ready   = p0_ready_q;
    assign bus.p1_ready   = p1_ready_q;
    assign busy           = busy_q;
endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: directed scenarios plus a randomized run
// compared against a transaction-timeline model of the arbiter.
`timescale 1ns/1ps
module tb_dram_arbiter;
    localparam int unsigned ADDR_W = 27;
    localparam int unsigned DATA_W = 32;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   checks   = 0;
    int   failures = 0;

    // DRAM model controls
    bit                resp_en;
    int                dram_lat;
    logic              stray_ready;
    logic [DATA_W-1:0] dram_mem [logic [ADDR_W-1:0]];

    always #5 clk = ~clk;

    dram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    function automatic logic [DATA_W-1:0] fill(input logic [ADDR_W-1:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // DRAM: answers the dram_lat-th cycle that valid_dram is seen high
    initial begin : dram_model
        int cnt;
        bit fired;
        cnt = 0;
        fired = 0;
        bus.ready_dram = 1'b0;
        bus.dout_dram  = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!resp_en) begin
                bus.ready_dram = stray_ready;
                bus.dout_dram  = 32'hBAD0_BAD0;
                cnt = 0;
                fired = 0;
            end else begin
                bus.ready_dram = 1'b0;
                if (bus.valid_dram !== 1'b1) begin
                    cnt = 0;
                    fired = 0;
                end else if (!fired) begin
                    cnt++;
                    if (cnt >= dram_lat) begin
                        fired = 1;
                        bus.ready_dram = 1'b1;
                        if (bus.rw_dram) dram_mem[bus.addr_dram] = bus.din_dram;
                        bus.dout_dram = dram_mem.exists(bus.addr_dram) ? dram_mem[bus.addr_dram]
                                                                       : fill(bus.addr_dram);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.valid_dram, bus.rw_dram, bus.addr_dram, bus.din_dram, busy} !== '0) begin
            failures++;
            $display("FAIL reset_dram_fields: got valid=%b rw=%b addr=%h din=%h busy=%b, want all 0",
                     bus.valid_dram, bus.rw_dram, bus.addr_dram, bus.din_dram, busy);
        end
        checks++;
        if ({bus.p0_ready, bus.p1_ready, bus.p0_dout, bus.p1_dout} !== '0) begin
            failures++;
            $display("FAIL reset_ports: got rdy0=%b rdy1=%b dout0=%h dout1=%h, want all 0",
                     bus.p0_ready, bus.p1_ready, bus.p0_dout, bus.p1_dout);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        int nvalid;
        dram_lat = 5;
        dram_mem[27'h100] = 32'hDEAD_BEEF;
        bus.p0_valid = 1'b1; bus.p0_addr = 27'h100; bus.p0_din = $urandom; bus.p0_rw = 1'b0;
        nvalid = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (bus.valid_dram === 1'b1 && bus.addr_dram === 27'h100 && bus.p0_ready === 1'b0)
                nvalid++;
        end
        checks++;
        if (nvalid != 5) begin
            failures++;
            $display("FAIL single_read_valid_cycles: got %0d, want 5", nvalid);
        end
        tick();
        checks++;
        if ({bus.p0_ready, bus.p1_ready, bus.valid_dram} !== 3'b100) begin
            failures++;
            $display("FAIL single_read_ready: got rdy0=%b rdy1=%b valid=%b, want 1 0 0",
                     bus.p0_ready, bus.p1_ready, bus.valid_dram);
        end
        checks++;
        if (bus.p0_dout !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL single_read_data: got %h, want deadbeef", bus.p0_dout);
        end
        bus.p0_valid = 1'b0;
        tick();
        checks++;
        if ({bus.p0_ready, busy} !== 2'b00) begin
            failures++;
            $display("FAIL single_read_after: got rdy0=%b busy=%b, want 0 0", bus.p0_ready, busy);
        end
    endtask

    task automatic test_write_read();
        dram_lat = 2;
        bus.p1_valid = 1'b1; bus.p1_addr = 27'h40; bus.p1_din = 32'h1234_5678; bus.p1_rw = 1'b1;
        tick();
        checks++;
        if ({bus.valid_dram, bus.rw_dram, bus.addr_dram, bus.din_dram} !== {1'b1, 1'b1, 27'h40, 32'h1234_5678}) begin
            failures++;
            $display("FAIL write_fields: got valid=%b rw=%b addr=%h din=%h, want 1 1 0000040 12345678",
                     bus.valid_dram, bus.rw_dram, bus.addr_dram, bus.din_dram);
        end
        tick();
        tick();
        checks++;
        if (bus.p1_ready !== 1'b1 || bus.p1_dout !== 32'h0) begin
            failures++;
            $display("FAIL write_complete: got rdy1=%b dout1=%h, want 1 00000000", bus.p1_ready, bus.p1_dout);
        end
        bus.p1_rw = 1'b0; bus.p1_din = $urandom;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL write_read_idle: got busy=%b, want 0", busy);
        end
        tick(); tick(); tick();
        checks++;
        if (bus.p1_ready !== 1'b1 || bus.p1_dout !== 32'h1234_5678) begin
            failures++;
            $display("FAIL read_back: got rdy1=%b dout1=%h, want 1 12345678", bus.p1_ready, bus.p1_dout);
        end
        bus.p1_valid = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        int n;
        int exp;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dram_lat = 2;
        bus.p0_valid = 1'b1; bus.p0_addr = 27'h10; bus.p0_rw = 1'b0; bus.p0_din = $urandom;
        bus.p1_valid = 1'b1; bus.p1_addr = 27'h20; bus.p1_rw = 1'b0; bus.p1_din = $urandom;
        for (int t = 0; t < 4; t++) begin
`ifdef DRAM_ARB_FIXED_PRIO_EN
            exp = 1;
`else
            exp = t % 2;
`endif
            n = 0;
            while (bus.valid_dram !== 1'b1 && n < 10) begin tick(); n++; end
            checks++;
            if (bus.addr_dram !== ((exp == 1) ? 27'h20 : 27'h10)) begin
                failures++;
                $display("FAIL contention_grant_%0d: got addr=%h, want port %0d", t, bus.addr_dram, exp);
            end
            n = 0;
            while (bus.p0_ready !== 1'b1 && bus.p1_ready !== 1'b1 && n < 10) begin tick(); n++; end
            checks++;
            if ({bus.p1_ready, bus.p0_ready} !== ((exp == 1) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL contention_ready_%0d: got rdy1/rdy0=%b%b, want port %0d",
                         t, bus.p1_ready, bus.p0_ready, exp);
            end
        end
        bus.p0_valid = 1'b0;
        bus.p1_valid = 1'b0;
        tick();
    endtask

    task automatic test_late_arrival();
        dram_lat = 4;
        bus.p0_valid = 1'b1; bus.p0_addr = 27'h11; bus.p0_rw = 1'b0;
        tick(); tick();
        bus.p1_valid = 1'b1; bus.p1_addr = 27'h33; bus.p1_rw = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (bus.p0_ready !== 1'b1 || bus.p1_ready !== 1'b0) begin
            failures++;
            $display("FAIL late_p0_ready: got rdy0=%b rdy1=%b, want 1 0", bus.p0_ready, bus.p1_ready);
        end
        bus.p0_valid = 1'b0;
        tick();
        checks++;
        if ({bus.valid_dram, busy} !== 2'b00) begin
            failures++;
            $display("FAIL late_idle: got valid=%b busy=%b, want 0 0", bus.valid_dram, busy);
        end
        tick();
        checks++;
        if (bus.valid_dram !== 1'b1 || bus.addr_dram !== 27'h33) begin
            failures++;
            $display("FAIL late_grant: got valid=%b addr=%h, want 1 0000033", bus.valid_dram, bus.addr_dram);
        end
        tick(); tick(); tick(); tick();
        checks++;
        if (bus.p1_ready !== 1'b1 || bus.p1_dout !== fill(27'h33)) begin
            failures++;
            $display("FAIL late_p1_done: got rdy1=%b dout1=%h, want 1 %h", bus.p1_ready, bus.p1_dout, fill(27'h33));
        end
        bus.p1_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bit clean;
        dram_lat = 5;
        bus.p0_valid = 1'b1; bus.p0_addr = 27'h55; bus.p0_rw = 1'b0;
        tick(); tick();
        resp_en = 1'b0;
        stray_ready = 1'b0;
        rst = 1'b1;
        bus.p0_valid = 1'b0;
        tick();
        rst = 1'b0;
        clean = 1'b1;
        for (int i = 0; i < 6; i++) begin
            stray_ready = (i == 1);
            if ({bus.p0_ready, bus.p1_ready, bus.valid_dram, busy} !== 4'b0000) clean = 1'b0;
            tick();
        end
        checks++;
        if (!clean) begin
            failures++;
            $display("FAIL reset_mid_quiet: got activity after abort (rdy/valid/busy), want none");
        end
        checks++;
        if ({bus.p0_dout, bus.p1_dout} !== '0) begin
            failures++;
            $display("FAIL reset_mid_dout: got dout0=%h dout1=%h, want 0 0", bus.p0_dout, bus.p1_dout);
        end
        resp_en = 1'b1;
        tick();
    endtask

    task automatic test_immediate_ready();
        logic [DATA_W-1:0] wd;
        dram_lat = 1;
        wd = $urandom;
        bus.p1_valid = 1'b1; bus.p1_addr = 27'h7; bus.p1_rw = 1'b0;
        tick();
        checks++;
        if (bus.valid_dram !== 1'b1 || bus.addr_dram !== 27'h7) begin
            failures++;
            $display("FAIL imm_valid: got valid=%b addr=%h, want 1 0000007", bus.valid_dram, bus.addr_dram);
        end
        tick();
        checks++;
        if (bus.p1_ready !== 1'b1 || bus.p1_dout !== fill(27'h7)) begin
            failures++;
            $display("FAIL imm_ready: got rdy1=%b dout1=%h, want 1 %h", bus.p1_ready, bus.p1_dout, fill(27'h7));
        end
        bus.p1_valid = 1'b0;
        bus.p0_valid = 1'b1; bus.p0_addr = 27'h9; bus.p0_rw = 1'b1; bus.p0_din = wd;
        tick();
        checks++;
        if (bus.valid_dram !== 1'b0) begin
            failures++;
            $display("FAIL imm_gap: got valid=%b, want 0", bus.valid_dram);
        end
        tick();
        checks++;
        if ({bus.valid_dram, bus.rw_dram, bus.addr_dram, bus.din_dram} !== {1'b1, 1'b1, 27'h9, wd}) begin
            failures++;
            $display("FAIL imm_next: got valid=%b rw=%b addr=%h din=%h, want 1 1 0000009 %h",
                     bus.valid_dram, bus.rw_dram, bus.addr_dram, bus.din_dram, wd);
        end
        tick();
        checks++;
        if (bus.p0_ready !== 1'b1 || bus.p0_dout !== 32'h0) begin
            failures++;
            $display("FAIL imm_write_done: got rdy0=%b dout0=%h, want 1 00000000", bus.p0_ready, bus.p0_dout);
        end
        bus.p0_valid = 1'b0;
        tick();
    endtask

    // Timeline model: a grant at cycle g with DRAM latency L gives valid_dram in g+1..g+L,
    // the ready pulse at g+L+1 and the next arbitration no earlier than g+L+2.
    task automatic test_random();
        bit                pend [2];
        logic [ADDR_W-1:0] ra   [2];
        logic [DATA_W-1:0] rd   [2];
        bit                rrw  [2];
        logic [DATA_W-1:0] exp_dout [2];
        logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
        bit   active;
        int   g, lat, cur, last;
        logic ev, eb;
        logic [1:0] er;
        active = 0; g = 0; lat = 0; cur = 0; last = 1;
        for (int p = 0; p < 2; p++) begin pend[p] = 0; exp_dout[p] = '0; end
        rst = 1'b1;
        bus.p0_valid = 1'b0;
        bus.p1_valid = 1'b0;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (active && c == g + lat + 2) active = 0;
            if (active && c == g + lat + 1) begin
                if (rrw[cur]) ref_mem[ra[cur]] = rd[cur];
                else exp_dout[cur] = ref_mem.exists(ra[cur]) ? ref_mem[ra[cur]] : fill(ra[cur]);
            end
            ev = active && c > g && c <= g + lat;
            eb = active && c > g;
            er = (active && c == g + lat + 1) ? ((cur == 1) ? 2'b10 : 2'b01) : 2'b00;
            checks++;
            if (bus.valid_dram !== ev) begin
                failures++;
                $display("FAIL rand_valid c%0d: got %b, want %b", c, bus.valid_dram, ev);
            end
            checks++;
            if (busy !== eb) begin
                failures++;
                $display("FAIL rand_busy c%0d: got %b, want %b", c, busy, eb);
            end
            checks++;
            if ({bus.p1_ready, bus.p0_ready} !== er) begin
                failures++;
                $display("FAIL rand_ready c%0d: got %b%b, want %b", c, bus.p1_ready, bus.p0_ready, er);
            end
            checks++;
            if (bus.p0_dout !== exp_dout[0] || bus.p1_dout !== exp_dout[1]) begin
                failures++;
                $display("FAIL rand_dout c%0d: got %h %h, want %h %h", c, bus.p0_dout, bus.p1_dout,
                         exp_dout[0], exp_dout[1]);
            end
            if (ev) begin
                checks++;
                if ({bus.addr_dram, bus.din_dram, bus.rw_dram} !== {ra[cur], rd[cur], rrw[cur]}) begin
                    failures++;
                    $display("FAIL rand_fields c%0d: got %h %h %b, want %h %h %b", c, bus.addr_dram,
                             bus.din_dram, bus.rw_dram, ra[cur], rd[cur], rrw[cur]);
                end
            end
            if (er != 2'b00) pend[cur] = 0;
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p] = 1;
                    ra[p]   = 27'h400 + 27'($urandom_range(0, 7));
                    rd[p]   = $urandom;
                    rrw[p]  = 1'($urandom_range(0, 1));
                end
            end
            bus.p0_valid = pend[0];
            bus.p0_addr  = pend[0] ? ra[0] : 27'($urandom);
            bus.p0_din   = pend[0] ? rd[0] : $urandom;
            bus.p0_rw    = pend[0] ? rrw[0] : 1'($urandom);
            bus.p1_valid = pend[1];
            bus.p1_addr  = pend[1] ? ra[1] : 27'($urandom);
            bus.p1_din   = pend[1] ? rd[1] : $urandom;
            bus.p1_rw    = pend[1] ? rrw[1] : 1'($urandom);
            if (!active && (pend[0] || pend[1])) begin
                if (pend[0] && pend[1]) begin
`ifdef DRAM_ARB_FIXED_PRIO_EN
                    cur = 1;
`else
                    cur = 1 - last;
`endif
                end else begin
                    cur = pend[1] ? 1 : 0;
                end
                last     = cur;
                active   = 1;
                g        = c;
                lat      = $urandom_range(1, 5);
                dram_lat = lat;
            end
            tick();
        end
        bus.p0_valid = 1'b0;
        bus.p1_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
    endtask

    initial begin : main
        rst = 1'b1;
        resp_en = 1'b1;
        stray_ready = 1'b0;
        dram_lat = 1;
        bus.p0_valid = 1'b0; bus.p0_addr = '0; bus.p0_din = '0; bus.p0_rw = 1'b0;
        bus.p1_valid = 1'b0; bus.p1_addr = '0; bus.p1_din = '0; bus.p1_rw = 1'b0;
        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_late_arrival();
        test_reset_mid();
        test_immediate_ready();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
